bcd_digit_sequencer: RTL and testbench



---
 rtl/bcd_pkg.sv | 40 ++++
 rtl/div10_iter.sv | 64 ++++++
 rtl/bcd_digit_sequencer.sv | 145 ++++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared constants, FSM state encoding and helper functions for the
// binary-to-BCD digit sequencer and its iterative divide-by-10 unit.
// Optional feature macro used by the sequencer: BCD_LZ_BLANK_EN.
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W      = 4;
    localparam int         VALUE_W      = 14;
    localparam int         DIV_LAT      = 11;
    localparam logic [3:0] BCD_OVF_CODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } bcd_state_e;

    // 10^digits - 1, the largest value that fits in 'digits' BCD digits.
    function automatic int max_val(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        return m - 1;
    endfunction

    // One restoring shift-subtract step of a divide-by-10.
    // r is the partial remainder (always < 10), b the next dividend bit.
    // Returns {quotient_bit, new_remainder}.
    function automatic logic [4:0] div10_step(input logic [3:0] r, input logic b);
        logic [4:0] t;
        t = {r, b};
        if (t >= 5'd10) return {1'b1, 4'(t - 5'd10)};
        else            return {1'b0, t[3:0]};
    endfunction

endpackage

// File: rtl/div10_iter.sv
// ---------------------------------------------------------------------------
// div10_iter
// Iterative restoring divide-by-10 for a 14-bit operand.
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   start  in   one-cycle pulse; value is captured on this edge
//   value  in   14-bit dividend
//   quot   out  14-bit quotient (value / 10), valid while ready=1
//   rem    out  4-bit remainder (value % 10), valid while ready=1
//   ready  out  low for DIV_LAT cycles after start, then high and held
//
// The quotient of a 14-bit value by 10 is at most 1638, so quotient bits
// 13..11 are always zero and the top three dividend bits (<= 7) seed the
// remainder directly. The start edge also performs the step for bit 10,
// leaving DIV_LAT-1 steps for bits 9..0.
// ---------------------------------------------------------------------------
module div10_iter
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic [VALUE_W-1:0] quot,
    output logic [DIGIT_W-1:0] rem,
    output logic               ready
);

    logic [9:0]  dvd;     // dividend bits still to be consumed, MSB first
    logic [10:0] q_r;     // quotient bits 10..0, shifted in LSB first
    logic [3:0]  r_r;     // partial remainder
    logic [3:0]  cnt;     // steps remaining
    logic [4:0]  first_step;
    logic [4:0]  next_step;

    assign first_step = div10_step({1'b0, value[13:11]}, value[10]);
    assign next_step  = div10_step(r_r, dvd[9]);

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (start) begin
            r_r   <= first_step[3:0];
            q_r   <= {10'b0, first_step[4]};
            dvd   <= value[9:0];
            cnt   <= 4'(DIV_LAT - 1);
            ready <= 1'b0;
        end else if (cnt != 4'd0) begin
            r_r <= next_step[3:0];
            q_r <= {q_r[9:0], next_step[4]};
            dvd <= {dvd[8:0], 1'b0};
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) ready <= 1'b1;
        end
    end

    assign quot = {3'b000, q_r};
    assign rem  = r_r;

endmodule

// File: rtl/bcd_digit_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_digit_sequencer
// Converts a 14-bit binary value into DIGITS packed BCD digits by driving one
// shared div10_iter repeatedly: each remainder is a digit (units first) and
// each quotient becomes the next dividend.
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   conversion request, sampled only in IDLE
//   value      in   14-bit operand, captured on the accepted start
//   busy       out  high from the cycle after an accepted start through done
//   done       out  one-cycle pulse in the FIN cycle; digits/ovf/blank take
//                   their new values on the closing edge of that cycle
//   ovf        out  captured value > 10^DIGITS-1, held until next result
//   digits     out  packed BCD, digit 0 (units) in [3:0]; all 4'hF on ovf
//   blank      out  (only with BCD_LZ_BLANK_EN) leading-zero blank per digit
//   state_dbg  out  current FSM state (bcd_state_e encoding)
//
// Handshake: start is a level sampled on each rising edge while IDLE; any
// start seen in another state is dropped, never queued. Reset wins over start.
//
// Optional feature macro: BCD_LZ_BLANK_EN.
// ---------------------------------------------------------------------------
module bcd_digit_sequencer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [VALUE_W-1:0]        value,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic [DIGIT_W*DIGITS-1:0] digits,
`ifdef BCD_LZ_BLANK_EN
    output logic [DIGITS-1:0]         blank,
`endif
    output logic [2:0]                state_dbg
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_ISSUE = ST_ISSUE;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_STORE = ST_STORE;
    localparam logic [2:0] S_FIN   = ST_FIN;

    localparam logic [VALUE_W-1:0] MAXVAL = VALUE_W'(max_val(DIGITS));
    localparam logic [1:0]         K_LAST = 2'(DIGITS - 1);

    logic [2:0]                state;
    logic [VALUE_W-1:0]        work;
    logic [1:0]                k;
    logic [DIGIT_W*DIGITS-1:0] shadow;
    logic                      ovf_n;

    logic                      div_start;
    logic [VALUE_W-1:0]        div_quot;
    logic [DIGIT_W-1:0]        div_rem;
    logic                      div_ready;

    assign div_start = (state == S_ISSUE);

    div10_iter u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .value (work),
        .quot  (div_quot),
        .rem   (div_rem),
        .ready (div_ready)
    );

`ifdef BCD_LZ_BLANK_EN
    // Digit i blanks when it and every higher digit are zero; the units digit
    // never blanks so a zero value still shows "0". Nothing blanks on ovf.
    logic [DIGITS-1:0] blank_n;
    logic              higher_zero;

    always_comb begin
        blank_n     = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (shadow[DIGIT_W*i +: DIGIT_W] == 4'd0);
            blank_n[i]  = higher_zero && !ovf_n;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            work   <= '0;
            k      <= '0;
            shadow <= '0;
            ovf_n  <= 1'b0;
            digits <= '0;
            ovf    <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            blank  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work  <= value;
                        k     <= '0;
                        ovf_n <= (value > MAXVAL);
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (div_ready) state <= S_STORE;
                end
                S_STORE: begin
                    shadow[DIGIT_W*k +: DIGIT_W] <= div_rem;
                    work <= div_quot;
                    if (k == K_LAST) begin
                        state <= S_FIN;
                    end else begin
                        k     <= k + 2'd1;
                        state <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    // Full conversion always runs; on overflow the digits
                    // computed are discarded in favour of the marker code.
                    digits <= ovf_n ? {DIGITS{BCD_OVF_CODE}} : shadow;
                    ovf    <= ovf_n;
`ifdef BCD_LZ_BLANK_EN
                    blank  <= blank_n;
`endif
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_sequencer
// Self-checking bench for bcd_digit_sequencer. A transaction-level model
// (elapsed-cycle counter plus an expected-result queue computed with / and %)
// is compared with the DUT on every falling edge; directed tests pin the
// model with literal expectations. Build with +define+BCD_LZ_BLANK_EN to
// also check the blank output.
// ---------------------------------------------------------------------------
module tb_bcd_digit_sequencer;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 10 ** DIGITS - 1;
    localparam int LAT    = DIGITS * (DIV_LAT + 2) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              start = 1'b0;
    logic [13:0]       value = '0;
    logic              busy, done, ovf;
    logic [W-1:0]      digits;
    logic [2:0]        state_dbg;
`ifdef BCD_LZ_BLANK_EN
    logic [DIGITS-1:0] blank;
`endif

    always #5 clk = ~clk;

    bcd_digit_sequencer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .digits    (digits),
`ifdef BCD_LZ_BLANK_EN
        .blank     (blank),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] conv(input int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        if (v > MAXV) begin
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
            return r;
        end
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i (i>=1) is blank exactly when the value is below 10^i.
    function automatic logic [DIGITS-1:0] blank_of(input int v);
        logic [DIGITS-1:0] b;
        int p;
        b = '0;
        if (v > MAXV) return b;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    // ---------------- behavioural model / scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    bit                m_busy   = 1'b0;
    int                m_t      = 0;
    int                m_val    = 0;
    logic [W-1:0]      m_digits = '0;
    logic              m_ovf    = 1'b0;
    logic [DIGITS-1:0] m_blank  = '0;
    logic [W-1:0]      m_pop;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_t      <= 0;
            m_digits <= '0;
            m_ovf    <= 1'b0;
            m_blank  <= '0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_t    <= 1;
                m_val  <= int'(value);
                exp_q.push_back(conv(int'(value)));
            end
        end else if (m_t == LAT) begin
            m_pop = exp_q.pop_front();
            m_busy   <= 1'b0;
            m_digits <= m_pop;
            m_ovf    <= (m_val > MAXV);
            m_blank  <= blank_of(m_val);
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_busy",   busy,   m_busy);
            check("mon_done",   done,   (m_busy && m_t == LAT));
            check("mon_digits", digits, m_digits);
            check("mon_ovf",    ovf,    m_ovf);
`ifdef BCD_LZ_BLANK_EN
            check("mon_blank",  blank,  m_blank);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge with the DUT idle; returns at the falling edge
    // of the cycle after done, with start already low.
    task automatic run_conv(input int v, input logic [W-1:0] ed, input logic eo,
                            input logic [DIGITS-1:0] eb);
        int n;
        start = 1'b1;
        value = 14'(v);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        check("latency",   n,    LAT);
        check("busy_at_done", busy, 1'b1);
        @(negedge clk);
        check("digits", digits, ed);
        check("ovf",    ovf,    eo);
        check("idle_after_done", busy, 1'b0);
`ifdef BCD_LZ_BLANK_EN
        check("blank", blank, eb);
`else
        if (eb != eb) check("blank_unused", 1'b0, 1'b1);
`endif
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int ndone;
        int dc[3];
        int c;

        // Model pins: hand-computed literals.
        check("model_1234",  conv(1234),  16'h1234);
        check("model_10000", conv(10000), 16'hFFFF);
        check("model_blank42", blank_of(42), 4'b1100);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_digits", digits, 16'h0000);
        check("rst_ovf",    ovf,    1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed conversions, back-to-back.
        run_conv(1234,  16'h1234, 1'b0, 4'b0000);
        run_conv(0,     16'h0000, 1'b0, 4'b1110);
        run_conv(9999,  16'h9999, 1'b0, 4'b0000);
        run_conv(10000, 16'hFFFF, 1'b1, 4'b0000);
        run_conv(16383, 16'hFFFF, 1'b1, 4'b0000);
        run_conv(7,     16'h0007, 1'b0, 4'b1110);
        run_conv(100,   16'h0100, 1'b0, 4'b1000);

        // start held high: only starts seen in IDLE are taken.
        ndone = 0;
        start = 1'b1;
        value = 14'd42;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (ndone < 3) dc[ndone] = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_count", ndone, 3);
        check("held_done0", dc[0], 53);
        check("held_done1", dc[1], 107);
        check("held_done2", dc[2], 161);
        drain(200);
        check("held_digits", digits, 16'h0042);

        // Reset in cycle 20 of a conversion.
        start = 1'b1;
        value = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 20) begin
            @(negedge clk);
            c++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",   busy,   1'b0);
        check("midrst_done",   done,   1'b0);
        check("midrst_digits", digits, 16'h0000);
        check("midrst_ovf",    ovf,    1'b0);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_conv(5678, 16'h5678, 1'b0, 4'b0000);

        // Randomized traffic with stray starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       value = 14'd0;
                1:       value = 14'd9999;
                2:       value = 14'd10000;
                3:       value = 14'd16383;
                default: value = 14'($urandom_range(0, 16383));
            endcase
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        drain(200);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
